idli_sqi_ctrl_m: RTL and testbench

IDLI_SQI_CTRL_M -- requirements
Module: idli_sqi_ctrl_m

---
 rtl/idli_sqi_ctrl_m.sv | 174 +++++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_ctrl_m
// Brief    : SQI (quad SPI) read controller serving fetch and immediate words.
//            Optional IDLI_SQI_SEQ_FETCH_EN: sequential fetches continue the burst.
// Revision : 1.0 - initial release
// ============================================================================

typedef logic [3:0] sqi_data_t;

module idli_sqi_ctrl_m #(
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic      i_sqi_gck,
  input  logic      i_sqi_rst,
  input  logic      i_sqi_fetch_req,
  input  logic [15:0] i_sqi_fetch_addr,
  output logic      o_sqi_fetch_gnt,
  input  logic      i_sqi_imm_req,
  output logic      o_sqi_imm_gnt,
  output logic      o_sqi_cs_n,
  output logic [3:0] o_sqi_sio,
  output logic      o_sqi_sio_oe,
  input  logic [3:0] i_sqi_sio,
  output sqi_data_t o_sqi_data,
  output logic      o_sqi_data_vld,
  output logic      o_sqi_data_id
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [2:0] c_dummy_last = 3'(DUMMY_NIBBLES - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_nib;
  logic [15:0] r_nxt;
  logic        r_owner;

  logic        w_boundary;
  logic        w_accept;
  logic        w_cont;
  logic [15:0] w_nxt_inc;
  logic [23:0] w_baddr;
  logic [3:0]  w_addr_nib;

  assign w_boundary      = (r_state == S_DATA) && (r_nib == 2'd3);
  assign w_accept        = !i_sqi_rst && ((r_state == S_IDLE) || w_boundary);
  assign o_sqi_imm_gnt   = w_accept && i_sqi_imm_req;
  assign o_sqi_fetch_gnt = w_accept && i_sqi_fetch_req && !i_sqi_imm_req;
  assign w_nxt_inc       = r_nxt + 16'd1;
  assign w_baddr         = {7'b0, r_nxt, 1'b0};

`ifdef IDLI_SQI_SEQ_FETCH_EN
  assign w_cont = o_sqi_imm_gnt || (o_sqi_fetch_gnt && (i_sqi_fetch_addr == w_nxt_inc));
`else
  assign w_cont = o_sqi_imm_gnt;
`endif

  // Nibble to drive in the ADDR cycle after the one indexed by r_cnt.
  always_comb begin
    w_addr_nib = 4'h0;
    case (r_cnt)
      3'd0:    w_addr_nib = w_baddr[19:16];
      3'd1:    w_addr_nib = w_baddr[15:12];
      3'd2:    w_addr_nib = w_baddr[11:8];
      3'd3:    w_addr_nib = w_baddr[7:4];
      3'd4:    w_addr_nib = w_baddr[3:0];
      default: w_addr_nib = 4'h0;
    endcase
  end

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 3'd0;
      r_nib          <= 2'd0;
      r_nxt          <= 16'h0000;
      r_owner        <= 1'b0;
      o_sqi_cs_n     <= 1'b1;
      o_sqi_sio      <= 4'h0;
      o_sqi_sio_oe   <= 1'b0;
      o_sqi_data     <= 4'h0;
      o_sqi_data_vld <= 1'b0;
      o_sqi_data_id  <= 1'b0;
    end else begin
      o_sqi_data_vld <= (r_state == S_DATA);
      o_sqi_data     <= i_sqi_sio;
      o_sqi_data_id  <= r_owner;
      case (r_state)
        S_IDLE: begin
          if (o_sqi_fetch_gnt || o_sqi_imm_gnt) begin
            r_state      <= S_CMD;
            r_cnt        <= 3'd0;
            r_owner      <= o_sqi_imm_gnt;
            r_nxt        <= o_sqi_imm_gnt ? r_nxt : i_sqi_fetch_addr;
            o_sqi_cs_n   <= 1'b0;
            o_sqi_sio_oe <= 1'b1;
            o_sqi_sio    <= 4'h0;
          end
        end
        S_CMD: begin
          if (r_cnt == 3'd0) begin
            r_cnt     <= 3'd1;
            o_sqi_sio <= 4'h3;
          end else begin
            r_state   <= S_ADDR;
            r_cnt     <= 3'd0;
            o_sqi_sio <= w_baddr[23:20];
          end
        end
        S_ADDR: begin
          if (r_cnt == 3'd5) begin
            r_state      <= S_DUMMY;
            r_cnt        <= 3'd0;
            o_sqi_sio_oe <= 1'b0;
            o_sqi_sio    <= 4'h0;
          end else begin
            r_cnt     <= r_cnt + 3'd1;
            o_sqi_sio <= w_addr_nib;
          end
        end
        S_DUMMY: begin
          if (r_cnt == c_dummy_last) begin
            r_state <= S_DATA;
            r_nib   <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DATA: begin
          r_nib <= r_nib + 2'd1;
          if (w_boundary) begin
            if (o_sqi_fetch_gnt || o_sqi_imm_gnt) r_owner <= o_sqi_imm_gnt;
            if (w_cont) begin
              r_nxt <= w_nxt_inc;
              // The memory's sequential stream cannot cross the 64K-word wrap.
              if (w_nxt_inc == 16'h0000) begin
                r_state    <= S_END;
                o_sqi_cs_n <= 1'b1;
              end
            end else if (o_sqi_fetch_gnt) begin
              r_nxt      <= i_sqi_fetch_addr;
              r_state    <= S_END;
              o_sqi_cs_n <= 1'b1;
            end else begin
              r_nxt      <= w_nxt_inc;
              r_state    <= S_IDLE;
              o_sqi_cs_n <= 1'b1;
            end
          end
        end
        S_END: begin
          r_state      <= S_CMD;
          r_cnt        <= 3'd0;
          o_sqi_cs_n   <= 1'b0;
          o_sqi_sio_oe <= 1'b1;
          o_sqi_sio    <= 4'h0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_ctrl_m
// Brief    : Bench for idli_sqi_ctrl_m with a nibble-addressed SQI memory model
//            and a word-level scoreboard of granted requests.
// Revision : 1.0 - initial release
// ============================================================================

module tb_idli_sqi_ctrl_m;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0;
  logic        fetch_gnt;
  logic        imm_req = 1'b0;
  logic        imm_gnt;
  logic        cs_n;
  logic [3:0]  sio_out;
  logic        sio_oe;
  logic [3:0]  sio_in = 4'h0;
  logic [3:0]  data;
  logic        data_vld;
  logic        data_id;

  idli_sqi_ctrl_m #(.DUMMY_NIBBLES(D)) dut (
    .i_sqi_gck       (clk),
    .i_sqi_rst       (rst),
    .i_sqi_fetch_req (fetch_req),
    .i_sqi_fetch_addr(fetch_addr),
    .o_sqi_fetch_gnt (fetch_gnt),
    .i_sqi_imm_req   (imm_req),
    .o_sqi_imm_gnt   (imm_gnt),
    .o_sqi_cs_n      (cs_n),
    .o_sqi_sio       (sio_out),
    .o_sqi_sio_oe    (sio_oe),
    .i_sqi_sio       (sio_in),
    .o_sqi_data      (data),
    .o_sqi_data_vld  (data_vld),
    .o_sqi_data_id   (data_id)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory contents: nibble at nibble-address p.
  function automatic logic [3:0] mem_nib(input int unsigned p);
    int unsigned h;
    h = (p * 13) ^ (p >> 5) ^ (p >> 11);
    return h[3:0];
  endfunction

  function automatic int L(input int x);
    return x & 8191;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sio_log [8192];
  bit cs_log [8192];
  bit oe_log [8192];
  bit vld_log[8192];
  bit id_log [8192];

  // Memory model: decodes command/address from the bus and streams nibbles.
  int          mc = 0;
  logic [7:0]  cmd = 8'h0;
  logic [23:0] baddr = 24'h0;
  always @(negedge clk) begin
    if (rst || cs_n) begin
      mc = 0;
    end else begin
      chk("oe", sio_oe, (mc < 8) ? 1 : 0);
      if (mc < 2) begin
        cmd = {cmd[3:0], sio_out};
        if (mc == 1) chk("cmd", cmd, 8'h03);
      end else if (mc < 8) begin
        baddr = {baddr[19:0], sio_out};
        if (mc == 7) chk("addr_fmt", {baddr[23:17], baddr[0]}, 0);
      end
      if (mc >= 8 + D) sio_in = mem_nib(2 * baddr + (mc - 8 - D));
      mc++;
    end
  end

  // Scoreboard: every grant expects one word of four nibbles, in order.
  logic [4:0]  sbq[$];
  logic [4:0]  sb_e;
  logic [15:0] m_nxt = 16'h0;
  logic [15:0] m_word;
  always @(negedge clk) begin
    sio_log[L(cyc)] = sio_out;
    cs_log[L(cyc)]  = cs_n;
    oe_log[L(cyc)]  = sio_oe;
    vld_log[L(cyc)] = data_vld;
    id_log[L(cyc)]  = data_id;
    if (rst) begin
      sbq.delete();
      m_nxt = 16'h0;
    end else begin
      if (data_vld) begin
        if (sbq.size() == 0) chk("vld_unexpected", 1, 0);
        else begin
          sb_e = sbq.pop_front();
          chk("data", {data_id, data}, sb_e);
        end
      end
      if (fetch_gnt || imm_gnt) begin
        chk("one_gnt", fetch_gnt && imm_gnt, 0);
        if (imm_gnt) m_word = m_nxt;
        else begin
          chk("imm_prio", imm_req, 0);
          m_word = fetch_addr;
        end
        m_nxt = m_word + 16'd1;
        for (int i = 0; i < 4; i++)
          sbq.push_back({imm_gnt, mem_nib(4 * int'(m_word) + i)});
      end
    end
  end

  // Holds each request (after its delay) until granted; records grant cycles.
  task automatic run_reqs(input bit do_f, input logic [15:0] fa, input int df,
                          input bit do_i, input int di, output int tf, output int ti);
    bit fdone, idone;
    fdone = !do_f; idone = !do_i; tf = -1; ti = -1;
    for (int k = 0; k < 300 && !(fdone && idone); k++) begin
      fetch_req  = !fdone && (k >= df);
      fetch_addr = fa;
      imm_req    = !idone && (k >= di);
      @(negedge clk);
      if (fetch_req && fetch_gnt) begin tf = cyc; fdone = 1; end
      if (imm_req && imm_gnt) begin ti = cyc; idone = 1; end
      @(posedge clk); #1;
      if (fdone) fetch_req = 1'b0;
      if (idone) imm_req = 1'b0;
    end
    fetch_req = 1'b0;
    imm_req   = 1'b0;
    chk("req_timeout", fdone && idone, 1);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int k = 0; k < 200 && quiet < 3; k++) begin
      @(negedge clk);
      if (cs_n && !data_vld) quiet++;
      else quiet = 0;
    end
    @(posedge clk); #1;
    chk("idle_timeout", quiet >= 3, 1);
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must drop at once.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_cs"}, cs_n, 1);
    chk({tag, "_oe"}, sio_oe, 0);
    chk({tag, "_vld"}, data_vld, 0);
    chk({tag, "_sio"}, sio_out, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int tf, ti, t0, t1;
  logic [3:0] exp28[8] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};

  initial begin
    fetch_req = 1'b1;
    imm_req   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs_n, 1);
    chk("rst_oe", sio_oe, 0);
    chk("rst_sio", sio_out, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_gnt", {fetch_gnt, imm_gnt}, 0);
    fetch_req = 1'b0;
    imm_req   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch timeline.
    run_reqs(1, 16'h1234, 0, 0, 0, tf, ti);
    t0 = tf;
    wait_idle();
    chk("r28_cs_pre", cs_log[L(t0)], 1);
    for (int k = 1; k <= 8; k++) begin
      chk("r28_sio", sio_log[L(t0 + k)], exp28[k-1]);
      chk("r28_oe", oe_log[L(t0 + k)], 1);
      chk("r28_cs", cs_log[L(t0 + k)], 0);
    end
    chk("r28_oe_off", oe_log[L(t0 + 9)], 0);
    chk("r28_vld_pre", vld_log[L(t0 + 11 + D - 2)], 0);
    for (int k = 0; k < 4; k++) begin
      chk("r28_vld", vld_log[L(t0 + 10 + D + k)], 1);
      chk("r28_id", id_log[L(t0 + 10 + D + k)], 0);
    end
    chk("r28_vld_post", vld_log[L(t0 + 14 + D)], 0);

    // Immediate held during a fetch stream.
    run_reqs(1, 16'h0040, 0, 1, 1, tf, ti);
    wait_idle();
    chk("r29_gnt_cycle", ti - tf, 12 + D);
    chk("r29_cs_hold", cs_log[L(ti + 1)], 0);
    chk("r29_cs_hold4", cs_log[L(ti + 4)], 0);
    chk("r29_id", id_log[L(ti + 5)], 1);
    chk("r29_cs_end", cs_log[L(ti + 5)], 1);

    // Fetch and immediate together at a word boundary.
    run_reqs(1, 16'h0050, 0, 0, 0, t0, ti);
    run_reqs(1, 16'h0100, 0, 1, 0, tf, ti);
    wait_idle();
    chk("r30_imm_first", ti - t0, 12 + D);
    chk("r30_fetch_next", tf - ti, 4);
    chk("r30_end", cs_log[L(tf + 1)], 1);
    chk("r30_cmd", cs_log[L(tf + 2)], 0);
    chk("r30_cmd_nib", sio_log[L(tf + 3)], 4'h3);
    for (int k = 0; k < 6; k++)
      chk("r30_addr", sio_log[L(tf + 4 + k)], (k == 3) ? 2 : 0);

    // Sequential continue across the address wrap.
    run_reqs(1, 16'hFFFF, 0, 0, 0, t0, ti);
    run_reqs(0, 16'h0, 0, 1, 0, tf, ti);
    wait_idle();
    chk("r31_gnt_cycle", ti - t0, 12 + D);
    chk("r31_end", cs_log[L(ti + 1)], 1);
    chk("r31_cmd", cs_log[L(ti + 2)], 0);
    for (int k = 0; k < 6; k++)
      chk("r31_addr", sio_log[L(ti + 4 + k)], 0);

    // Fetch of the next sequential word at the boundary.
    run_reqs(1, 16'h0010, 0, 0, 0, t0, ti);
    run_reqs(1, 16'h0011, 0, 0, 0, t1, ti);
    wait_idle();
    chk("r32_gnt_cycle", t1 - t0, 12 + D);
`ifdef IDLI_SQI_SEQ_FETCH_EN
    chk("r32_cs", cs_log[L(t1 + 1)], 0);
`else
    chk("r32_cs", cs_log[L(t1 + 1)], 1);
    chk("r32_cmd", cs_log[L(t1 + 2)], 0);
`endif

    // Reset in the middle of the address phase.
    run_reqs(1, 16'h0ABC, 0, 0, 0, tf, ti);
    repeat (3) @(posedge clk);
    #1;
    chk("r33_in_addr", sio_oe, 1);
    rst_pulse("r33");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("r33_idle_cs", cs_n, 1);
    end
    @(posedge clk); #1;

    // Reset during data, then an immediate from the reset next-word address.
    run_reqs(1, 16'h0777, 0, 0, 0, tf, ti);
    repeat (12 + D - 1) @(posedge clk);
    #1;
    chk("r25_pre_vld", data_vld, 1);
    rst_pulse("r25");
    run_reqs(0, 16'h0, 0, 1, 0, tf, ti);
    wait_idle();

    // Randomized request traffic with occasional resets.
    for (int it = 0; it < 60; it++) begin
      int sel, df, di;
      logic [15:0] a;
      sel = int'($urandom_range(0, 3));
      df  = int'($urandom_range(0, 12));
      di  = int'($urandom_range(0, 12));
      a   = 16'($urandom);
      case (sel)
        0: run_reqs(1, a, df, 0, 0, tf, ti);
        1: run_reqs(0, a, 0, 1, di, tf, ti);
        2: run_reqs(1, a, df, 1, di, tf, ti);
        default: run_reqs(1, m_nxt, df, 0, 0, tf, ti);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 15)) @(posedge clk);
        #1;
        rst_pulse("rnd_rst");
      end else begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
